issue_queue: RTL

Parametrised out-of-order issue queue between rename and execute in mips_core. It holds renamed instructions, tracks source-operand readiness by physical tag, and captures wakeup broadcasts from writeback. Each cycle it issues the oldest ready entry, ordered by active-list position. A branch mispredict squashes only the entries younger than the branch.

---
 rtl/issue_queue_if.sv | 42 ++++
 rtl/issue_queue.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/issue_queue_if.sv
// Rename/execute-facing bundle of the out-of-order issue queue: enqueue, wakeup,
// select/issue and flush signals, plus the active-list head used for age ordering.
interface issue_queue_if #(
  parameter int TAG_W      = 6,
  parameter int AL_W       = 5,
  parameter int PAYLOAD_W  = 96,
  parameter int WAKE_PORTS = 2
);
  logic                          enq_valid;
  logic                          enq_ready;
  logic [TAG_W-1:0]              enq_rs_tag;
  logic [TAG_W-1:0]              enq_rt_tag;
  logic                          enq_rs_rdy;
  logic                          enq_rt_rdy;
  logic [TAG_W-1:0]              enq_rw_tag;
  logic [AL_W-1:0]               enq_al_idx;
  logic [PAYLOAD_W-1:0]          enq_payload;
  logic [WAKE_PORTS-1:0]         wake_valid;
  logic [WAKE_PORTS*TAG_W-1:0]   wake_tag;
  logic [AL_W-1:0]               al_head;
  logic                          iss_valid;
  logic                          iss_ready;
  logic [TAG_W-1:0]              iss_rw_tag;
  logic [AL_W-1:0]               iss_al_idx;
  logic [PAYLOAD_W-1:0]          iss_payload;
  logic                          flush_valid;
  logic [AL_W-1:0]               flush_al_idx;

  modport master (
    output enq_valid, enq_rs_tag, enq_rt_tag, enq_rs_rdy, enq_rt_rdy,
           enq_rw_tag, enq_al_idx, enq_payload, wake_valid, wake_tag,
           al_head, iss_ready, flush_valid, flush_al_idx,
    input  enq_ready, iss_valid, iss_rw_tag, iss_al_idx, iss_payload
  );

  modport slave (
    input  enq_valid, enq_rs_tag, enq_rt_tag, enq_rs_rdy, enq_rt_rdy,
           enq_rw_tag, enq_al_idx, enq_payload, wake_valid, wake_tag,
           al_head, iss_ready, flush_valid, flush_al_idx,
    output enq_ready, iss_valid, iss_rw_tag, iss_al_idx, iss_payload
  );
endinterface

// File: rtl/issue_queue.sv
// Out-of-order issue queue: holds renamed instructions, captures wakeup tags and
// issues the oldest ready entry by active-list age; mispredicts squash younger entries.
module issue_queue #(
  parameter int DEPTH      = 32,
  parameter int TAG_W      = 6,
  parameter int AL_W       = 5,
  parameter int PAYLOAD_W  = 96,
  parameter int WAKE_PORTS = 2,
  localparam int IDX_W     = $clog2(DEPTH),
  localparam int CNT_W     = IDX_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  issue_queue_if.slave     bus,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [DEPTH-1:0]     rs_rdy_q, rs_rdy_d;
  logic [DEPTH-1:0]     rt_rdy_q, rt_rdy_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic [TAG_W-1:0]     rs_tag_q  [DEPTH];
  logic [TAG_W-1:0]     rt_tag_q  [DEPTH];
  logic [TAG_W-1:0]     rw_tag_q  [DEPTH];
  logic [AL_W-1:0]      al_idx_q  [DEPTH];
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];

  logic [DEPTH-1:0]     squash;
  logic [CNT_W-1:0]     squash_cnt;
  logic [IDX_W-1:0]     free_idx;
  logic [IDX_W-1:0]     sel_idx;
  logic [AL_W-1:0]      sel_age;
  logic                 sel_found;
  logic                 enq_fire;
  logic                 iss_fire;
  logic                 enq_rs_hit;
  logic                 enq_rt_hit;

  // Age relative to the active-list head; unsigned wrap gives the modulo.
  function automatic logic [AL_W-1:0] age_of(input logic [AL_W-1:0] idx,
                                             input logic [AL_W-1:0] head);
    return idx - head;
  endfunction

  function automatic logic wake_hit(input logic [TAG_W-1:0]            tag,
                                    input logic [WAKE_PORTS-1:0]       wv,
                                    input logic [WAKE_PORTS*TAG_W-1:0] wt);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WAKE_PORTS; p++) begin
      if (wv[p] && (wt[p*TAG_W +: TAG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  assign bus.enq_ready = (count_q != CNT_W'(DEPTH));
  assign enq_fire      = bus.enq_valid && bus.enq_ready && !bus.flush_valid;
  assign bus.iss_valid = sel_found && !bus.flush_valid;
  assign iss_fire      = bus.iss_valid && bus.iss_ready;
  assign count         = count_q;

  assign enq_rs_hit = wake_hit(bus.enq_rs_tag, bus.wake_valid, bus.wake_tag);
  assign enq_rt_hit = wake_hit(bus.enq_rt_tag, bus.wake_valid, bus.wake_tag);

  assign bus.iss_rw_tag  = bus.iss_valid ? rw_tag_q[sel_idx]  : '0;
  assign bus.iss_al_idx  = bus.iss_valid ? al_idx_q[sel_idx]  : '0;
  assign bus.iss_payload = bus.iss_valid ? payload_q[sel_idx] : '0;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  // Oldest-ready select; active-list indices are unique so no tie-break is needed.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '1;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && rs_rdy_q[i] && rt_rdy_q[i] &&
          (!sel_found || age_of(al_idx_q[i], bus.al_head) < sel_age)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = age_of(al_idx_q[i], bus.al_head);
      end
    end
  end

  always_comb begin
    squash     = '0;
    squash_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      squash[i] = bus.flush_valid && valid_q[i] &&
                  (age_of(al_idx_q[i], bus.al_head) > age_of(bus.flush_al_idx, bus.al_head));
      squash_cnt = squash_cnt + CNT_W'(squash[i]);
    end
  end

  // Enqueue only targets a free slot, so it never collides with squash or issue.
  always_comb begin
    valid_d  = valid_q;
    rs_rdy_d = rs_rdy_q;
    rt_rdy_d = rt_rdy_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        rs_rdy_d[i] = rs_rdy_q[i] || wake_hit(rs_tag_q[i], bus.wake_valid, bus.wake_tag);
        rt_rdy_d[i] = rt_rdy_q[i] || wake_hit(rt_tag_q[i], bus.wake_valid, bus.wake_tag);
      end
      if (squash[i] || (iss_fire && (sel_idx == IDX_W'(i)))) begin
        valid_d[i] = 1'b0;
      end else if (enq_fire && (free_idx == IDX_W'(i))) begin
        valid_d[i]  = 1'b1;
        rs_rdy_d[i] = bus.enq_rs_rdy || enq_rs_hit;
        rt_rdy_d[i] = bus.enq_rt_rdy || enq_rt_hit;
      end
    end
  end

  assign count_d = count_q + CNT_W'(enq_fire) - CNT_W'(iss_fire) - squash_cnt;

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      rs_rdy_q <= '0;
      rt_rdy_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      rs_rdy_q <= rs_rdy_d;
      rt_rdy_q <= rt_rdy_d;
      count_q  <= count_d;
    end
  end

  // NOTE: entry storage is not reset; it is only read once its valid bit is set.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      rs_tag_q[free_idx]  <= bus.enq_rs_tag;
      rt_tag_q[free_idx]  <= bus.enq_rt_tag;
      rw_tag_q[free_idx]  <= bus.enq_rw_tag;
      al_idx_q[free_idx]  <= bus.enq_al_idx;
      payload_q[free_idx] <= bus.enq_payload;
    end
  end

endmodule
